mem_stage_seq: RTL and testbench

- Parametrised successor of the pipeline memory stage.
- Owns the data memory and the address/write-data source selection.
- Adds a sequencer so 2W-wide values (PC push/pop for CALL/RET/INT/RTI) take two back-to-back word accesses, with a stall to the upstream pipeline.
- Sits between EX/MEM and MEM/WB registers; single-word accesses stay single-cycle.

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_array.sv | 28 ++
 rtl/mem_stage_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_stage_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: request opcodes, operand select codes
// and the sequencer state type.
package mem_stage_pkg;

    // Request opcodes; 5-7 decode as NOP.
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_RD1 = 3'd1;
    localparam logic [2:0] OP_WR1 = 3'd2;
    localparam logic [2:0] OP_WR2 = 3'd3;
    localparam logic [2:0] OP_RD2 = 3'd4;

    // Address source select.
    localparam logic [1:0] ASEL_RSRC = 2'd0;
    localparam logic [1:0] ASEL_RDST = 2'd1;
    localparam logic [1:0] ASEL_ALU  = 2'd2;
    localparam logic [1:0] ASEL_SP   = 2'd3;

    // Write-data source select; 5-7 select zero.
    localparam logic [2:0] DSEL_RSRC    = 3'd0;
    localparam logic [2:0] DSEL_RDST    = 3'd1;
    localparam logic [2:0] DSEL_FLAGS   = 3'd2;
    localparam logic [2:0] DSEL_PC      = 3'd3;
    localparam logic [2:0] DSEL_PC_PLUS = 3'd4;

    // Sequencer states: idle, pending low-word write, pending high-word read.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_RD_HI = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x W data RAM: synchronous write, read data presented from
// the addressed word and registered by the consuming stage at the same edge.
// Ports: clk; we_i write enable; addr_i word index; wdata_i write word;
//        rdata_c read word at addr_i.
module mem_array #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned IW    = 11
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [IW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_c
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_c = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_seq.sv
// Pipeline memory stage with a two-word sequencer for 2W-wide PC push/pop.
// Single-word RD1/WR1 complete in one cycle; WR2/RD2 take two back-to-back
// word accesses and raise stall for the second cycle.
// Optional feature macro MEM_BOUNDS_CHK_EN: addresses >= DEPTH set a sticky
// addr_err, suppress writes and read as zero. Without it DEPTH must be 2**AW.
// Ports: clk, rst (async active-low); req_valid/req_op request; addr_sel and
//        data_sel pick among rsrc/rdst/alu/sp/flags/pc/pc_plus; stall busy;
//        rd_valid/rd_data single read; pc_valid/pc_data double read; addr_err.
module mem_stage_seq
    import mem_stage_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned AW    = 11,
    parameter int unsigned DEPTH = 2048
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    input  logic [2:0]     req_op,
    input  logic [1:0]     addr_sel,
    input  logic [2:0]     data_sel,
    input  logic [W-1:0]   rsrc,
    input  logic [W-1:0]   rdst,
    input  logic [W-1:0]   alu,
    input  logic [W-1:0]   sp,
    input  logic [2*W-1:0] pc,
    input  logic [2*W-1:0] pc_plus,
    input  logic [2:0]     flags,
    output logic           stall,
    output logic           rd_valid,
    output logic [W-1:0]   rd_data,
    output logic           pc_valid,
    output logic [2*W-1:0] pc_data,
    output logic           addr_err
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e         state_q, state_d;
    logic [W-1:0]   a_src;
    logic [AW-1:0]  a_sel;
    logic [2*W-1:0] d2;
    logic [AW-1:0]  mem_addr;
    logic           mem_we;
    logic           ram_we;
    logic [W-1:0]   mem_wdata;
    logic [W-1:0]   ram_rdata;
    logic [W-1:0]   rdata;
    logic           oob;
    logic           unused_addr_bits;

    logic [AW-1:0]  seq_addr_q, seq_addr_d;
    logic [W-1:0]   seq_wdata_q, seq_wdata_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           rd_valid_q, rd_valid_d;
    logic [W-1:0]   rd_data_q, rd_data_d;
    logic           pc_valid_q, pc_valid_d;
    logic [2*W-1:0] pc_data_q, pc_data_d;

    // Address source mux; only the low AW bits form the word address.
    always_comb begin
        a_src = rsrc;
        case (addr_sel)
            ASEL_RSRC: a_src = rsrc;
            ASEL_RDST: a_src = rdst;
            ASEL_ALU:  a_src = alu;
            ASEL_SP:   a_src = sp;
            default:   a_src = rsrc;
        endcase
    end

    assign a_sel            = a_src[AW-1:0];
    assign unused_addr_bits = ^a_src[W-1:AW];

    // Double-width data mux; single-word sources are zero-extended.
    always_comb begin
        d2 = '0;
        case (data_sel)
            DSEL_RSRC:    d2 = (2*W)'(rsrc);
            DSEL_RDST:    d2 = (2*W)'(rdst);
            DSEL_FLAGS:   d2 = (2*W)'(flags);
            DSEL_PC:      d2 = pc;
            DSEL_PC_PLUS: d2 = pc_plus;
            default:      d2 = '0;
        endcase
    end

    // The second word of a sequence uses the latched address, not the inputs.
    assign mem_addr = (state_q == ST_IDLE) ? a_sel : seq_addr_q;
    assign stall    = (state_q != ST_IDLE);

`ifdef MEM_BOUNDS_CHK_EN
    logic acc;
    logic err_q, err_d;

    assign oob = (32'(mem_addr) >= DEPTH);

    // Any real memory access this cycle (first or second word).
    always_comb begin
        acc = 1'b0;
        if (state_q != ST_IDLE) begin
            acc = 1'b1;
        end else if (req_valid && (req_op == OP_RD1 || req_op == OP_WR1 ||
                                   req_op == OP_WR2 || req_op == OP_RD2)) begin
            acc = 1'b1;
        end
    end

    assign err_d = err_q | (acc & oob);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign addr_err = err_q;
`else
    assign oob      = 1'b0;
    assign addr_err = 1'b0;
`endif

    // Out-of-range reads return zero; writes are dropped, also while in reset.
    assign rdata  = oob ? '0 : ram_rdata;
    assign ram_we = mem_we & ~oob & rst;

    mem_array #(
        .W     (W),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (mem_addr[IW-1:0]),
        .wdata_i (mem_wdata),
        .rdata_c (ram_rdata)
    );

    // Sequencer next state, memory control and output next values.
    always_comb begin
        state_d     = state_q;
        mem_we      = 1'b0;
        mem_wdata   = d2[W-1:0];
        seq_addr_d  = seq_addr_q;
        seq_wdata_d = seq_wdata_q;
        lo_d        = lo_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        pc_valid_d  = 1'b0;
        pc_data_d   = pc_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_RD1: begin
                            rd_data_d  = rdata;
                            rd_valid_d = 1'b1;
                        end
                        OP_WR1: begin
                            mem_we = 1'b1;
                        end
                        OP_WR2: begin
                            // High word first at A, low word next at A-1.
                            mem_we      = 1'b1;
                            mem_wdata   = d2[2*W-1:W];
                            seq_addr_d  = a_sel - AW'(1);
                            seq_wdata_d = d2[W-1:0];
                            state_d     = ST_WR_LO;
                        end
                        OP_RD2: begin
                            // Low word at A, high word next at A+1.
                            lo_d       = rdata;
                            seq_addr_d = a_sel + AW'(1);
                            state_d    = ST_RD_HI;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_WR_LO: begin
                mem_we    = 1'b1;
                mem_wdata = seq_wdata_q;
                state_d   = ST_IDLE;
            end
            ST_RD_HI: begin
                pc_data_d  = {rdata, lo_q};
                pc_valid_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            seq_addr_q  <= '0;
            seq_wdata_q <= '0;
            lo_q        <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            pc_valid_q  <= 1'b0;
            pc_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            seq_addr_q  <= seq_addr_d;
            seq_wdata_q <= seq_wdata_d;
            lo_q        <= lo_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            pc_valid_q  <= pc_valid_d;
            pc_data_q   <= pc_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign pc_valid = pc_valid_q;
    assign pc_data  = pc_data_q;

endmodule

// File: tb/tb_mem_stage_seq.sv
// Self-checking bench for mem_stage_seq: directed vector table, bounds and
// reset sequences, and randomized traffic against a word-level memory model.
module tb_mem_stage_seq;

`ifdef MEM_BOUNDS_CHK_EN
    localparam int DEPTH_T = 1024;
`else
    localparam int DEPTH_T = 2048;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [1:0]  addr_sel = '0;
    logic [2:0]  data_sel = '0;
    logic [15:0] rsrc = '0, rdst = '0, alu = '0, sp = '0;
    logic [31:0] pc = '0, pc_plus = '0;
    logic [2:0]  flags = '0;
    logic        stall, rd_valid, pc_valid, addr_err;
    logic [15:0] rd_data;
    logic [31:0] pc_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_seq #(.W(16), .AW(11), .DEPTH(DEPTH_T)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .addr_sel(addr_sel), .data_sel(data_sel), .rsrc(rsrc), .rdst(rdst),
        .alu(alu), .sp(sp), .pc(pc), .pc_plus(pc_plus), .flags(flags),
        .stall(stall), .rd_valid(rd_valid), .rd_data(rd_data),
        .pc_valid(pc_valid), .pc_data(pc_data), .addr_err(addr_err)
    );

    // ---------------- reference model (word-level memory + pending access) ----
    logic [15:0] mref [0:2047];
    int          pend = 0;          // 0 none, 1 low write owed, 2 high read owed
    logic [10:0] pend_a;
    logic [15:0] pend_d, m_lo;
    logic        e_stall = 0, e_rdv = 0, e_pcv = 0, e_err = 0;
    logic [15:0] e_rd = '0;
    logic [31:0] e_pc = '0;

    function automatic logic [15:0] pat(input int a);
        return 16'(a * 37) ^ 16'hC3A5;
    endfunction

    function automatic logic [10:0] a_of();
        case (addr_sel)
            2'd0: return rsrc[10:0];
            2'd1: return rdst[10:0];
            2'd2: return alu[10:0];
            default: return sp[10:0];
        endcase
    endfunction

    function automatic logic [31:0] d2_of();
        case (data_sel)
            3'd0: return {16'h0, rsrc};
            3'd1: return {16'h0, rdst};
            3'd2: return {29'h0, flags};
            3'd3: return pc;
            3'd4: return pc_plus;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_wr(input logic [10:0] a, input logic [15:0] d);
        if (int'(a) >= DEPTH_T) e_err = 1'b1;
        else mref[a] = d;
    endtask

    task automatic m_rd(input logic [10:0] a, output logic [15:0] d);
        if (int'(a) >= DEPTH_T) begin
            e_err = 1'b1;
            d = 16'h0;
        end else begin
            d = mref[a];
        end
    endtask

    // Effects of the coming clock edge given the current inputs.
    task automatic model_edge();
        logic [10:0] a;
        logic [31:0] d2;
        logic [15:0] rv;
        e_rdv = 1'b0;
        e_pcv = 1'b0;
        a  = a_of();
        d2 = d2_of();
        if (pend == 0) begin
            if (req_valid) begin
                case (req_op)
                    3'd1: begin m_rd(a, rv); e_rd = rv; e_rdv = 1'b1; end
                    3'd2: m_wr(a, d2[15:0]);
                    3'd3: begin
                        m_wr(a, d2[31:16]);
                        pend = 1; pend_a = a - 11'd1; pend_d = d2[15:0];
                    end
                    3'd4: begin
                        m_rd(a, rv); m_lo = rv;
                        pend = 2; pend_a = a + 11'd1;
                    end
                    default: ;
                endcase
            end
        end else if (pend == 1) begin
            m_wr(pend_a, pend_d);
            pend = 0;
        end else begin
            m_rd(pend_a, rv);
            e_pc  = {rv, m_lo};
            e_pcv = 1'b1;
            pend  = 0;
        end
        e_stall = (pend != 0);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_stall"},    64'(stall),    64'(e_stall));
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(e_rdv));
        chk({tag, "_rd_data"},  64'(rd_data),  64'(e_rd));
        chk({tag, "_pc_valid"}, 64'(pc_valid), 64'(e_pcv));
        chk({tag, "_pc_data"},  64'(pc_data),  64'(e_pc));
        chk({tag, "_addr_err"}, 64'(addr_err), 64'(e_err));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [2:0] op, input logic [1:0] as,
                         input logic [15:0] av, input logic [2:0] ds,
                         input logic [15:0] dv, input logic [31:0] pcv);
        req_valid = rv; req_op = op; addr_sel = as; data_sel = ds;
        rsrc = av ^ 16'h0155; rdst = av ^ 16'h0155;
        alu  = av ^ 16'h0155; sp   = av ^ 16'h0155;
        flags = 3'b010; pc = ~pcv; pc_plus = ~pcv;
        case (ds)
            3'd1: rdst = dv;
            3'd2: flags = dv[2:0];
            3'd3: pc = pcv;
            3'd4: pc_plus = pcv;
            default: rsrc = dv;
        endcase
        case (as)
            2'd0: rsrc = av;
            2'd1: rdst = av;
            2'd2: alu = av;
            default: sp = av;
        endcase
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rv;
        logic [2:0]  op;
        logic [1:0]  as;
        logic [15:0] av;
        logic [2:0]  ds;
        logic [15:0] dv;
        logic [31:0] pcv;
        logic        e_st;
        logic        e_rv;
        logic [15:0] e_rd;
        logic        e_pv;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [2:0] op, input logic [1:0] as,
                                input logic [15:0] av, input logic [2:0] ds,
                                input logic [15:0] dv, input logic [31:0] pcv,
                                input logic est, input logic erv, input logic [15:0] erd,
                                input logic epv, input logic [31:0] epc);
        vec_t v;
        v.rv = rv; v.op = op; v.as = as; v.av = av; v.ds = ds; v.dv = dv; v.pcv = pcv;
        v.e_st = est; v.e_rv = erv; v.e_rd = erd; v.e_pv = epv; v.e_pc = epc;
        return v;
    endfunction

    vec_t tv [20];

    initial begin
        logic [15:0] rv;
        tv[0]  = mk(1, 3'd2, 2'd1, 16'h0010, 3'd0, 16'hBEEF, 32'h0,  0, 0, 16'h0000, 0, 32'h0);
        tv[1]  = mk(1, 3'd1, 2'd1, 16'h0010, 3'd0, 16'h0,    32'h0,  0, 1, 16'hBEEF, 0, 32'h0);
        tv[2]  = mk(1, 3'd3, 2'd3, 16'h07FF, 3'd4, 16'h0, 32'h1234_5678, 1, 0, 16'hBEEF, 0, 32'h0);
        tv[3]  = mk(1, 3'd2, 2'd3, 16'h07FE, 3'd0, 16'hDEAD, 32'h0,  0, 0, 16'hBEEF, 0, 32'h0);
        tv[4]  = mk(1, 3'd1, 2'd3, 16'h07FF, 3'd0, 16'h0,    32'h0,  0, 1, 16'h1234, 0, 32'h0);
        tv[5]  = mk(1, 3'd1, 2'd3, 16'h07FE, 3'd0, 16'h0,    32'h0,  0, 1, 16'h5678, 0, 32'h0);
        tv[6]  = mk(1, 3'd4, 2'd2, 16'h07FE, 3'd0, 16'h0,    32'h0,  1, 0, 16'h5678, 0, 32'h0);
        tv[7]  = mk(1, 3'd2, 2'd2, 16'h07FE, 3'd0, 16'h0000, 32'h0,  0, 0, 16'h5678, 1, 32'h1234_5678);
        tv[8]  = mk(1, 3'd1, 2'd2, 16'h07FE, 3'd0, 16'h0,    32'h0,  0, 1, 16'h5678, 0, 32'h1234_5678);
        tv[9]  = mk(1, 3'd3, 2'd3, 16'h0000, 3'd3, 16'h0, 32'hAAAA_5555, 1, 0, 16'h5678, 0, 32'h1234_5678);
        tv[10] = mk(0, 3'd1, 2'd3, 16'h0000, 3'd0, 16'h0,    32'h0,  0, 0, 16'h5678, 0, 32'h1234_5678);
        tv[11] = mk(1, 3'd4, 2'd2, 16'h07FF, 3'd0, 16'h0,    32'h0,  1, 0, 16'h5678, 0, 32'h1234_5678);
        tv[12] = mk(1, 3'd0, 2'd2, 16'h0000, 3'd0, 16'h0,    32'h0,  0, 0, 16'h5678, 1, 32'hAAAA_5555);
        tv[13] = mk(1, 3'd1, 2'd3, 16'h0000, 3'd0, 16'h0,    32'h0,  0, 1, 16'hAAAA, 0, 32'hAAAA_5555);
        tv[14] = mk(1, 3'd1, 2'd3, 16'h07FF, 3'd0, 16'h0,    32'h0,  0, 1, 16'h5555, 0, 32'hAAAA_5555);
        tv[15] = mk(1, 3'd5, 2'd3, 16'h0000, 3'd0, 16'h0,    32'h0,  0, 0, 16'h5555, 0, 32'hAAAA_5555);
        tv[16] = mk(1, 3'd2, 2'd1, 16'h0020, 3'd2, 16'h0005, 32'h0,  0, 0, 16'h5555, 0, 32'hAAAA_5555);
        tv[17] = mk(1, 3'd1, 2'd1, 16'h0020, 3'd0, 16'h0,    32'h0,  0, 1, 16'h0005, 0, 32'hAAAA_5555);
        tv[18] = mk(1, 3'd2, 2'd1, 16'h0021, 3'd5, 16'hFFFF, 32'h0,  0, 0, 16'h0005, 0, 32'hAAAA_5555);
        tv[19] = mk(1, 3'd1, 2'd1, 16'h0021, 3'd0, 16'h0,    32'h0,  0, 1, 16'h0000, 0, 32'hAAAA_5555);

        // Reset values.
        #2 rst = 1'b0;
        #2;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Known contents everywhere that exists.
        for (int a = 0; a < DEPTH_T; a++) begin
            drive(1, 3'd2, 2'd3, 16'(a), 3'd0, pat(a), 32'h0);
            step();
            compare_all("fill");
        end

`ifndef MEM_BOUNDS_CHK_EN
        for (int i = 0; i < 20; i++) begin
            drive(tv[i].rv, tv[i].op, tv[i].as, tv[i].av, tv[i].ds, tv[i].dv, tv[i].pcv);
            step();
            chk($sformatf("v%0d_stall", i),    64'(stall),    64'(tv[i].e_st));
            chk($sformatf("v%0d_rd_valid", i), 64'(rd_valid), 64'(tv[i].e_rv));
            chk($sformatf("v%0d_rd_data", i),  64'(rd_data),  64'(tv[i].e_rd));
            chk($sformatf("v%0d_pc_valid", i), 64'(pc_valid), 64'(tv[i].e_pv));
            chk($sformatf("v%0d_pc_data", i),  64'(pc_data),  64'(tv[i].e_pc));
            chk($sformatf("v%0d_addr_err", i), 64'(addr_err), 64'(0));
        end
`else
        // Out-of-range write: flagged, dropped, word 0 untouched.
        drive(1, 3'd2, 2'd3, 16'h0400, 3'd0, 16'h1111, 32'h0);
        step();
        chk("oob_wr_err", 64'(addr_err), 64'(1));
        compare_all("oob_wr");
        drive(1, 3'd1, 2'd3, 16'h0000, 3'd0, 16'h0, 32'h0);
        step();
        chk("oob_mem0", 64'(rd_data), 64'(pat(0)));
        compare_all("oob_rd0");
        drive(1, 3'd1, 2'd3, 16'h0400, 3'd0, 16'h0, 32'h0);
        step();
        chk("oob_rd_zero", 64'(rd_data), 64'(0));
        chk("oob_sticky", 64'(addr_err), 64'(1));
        compare_all("oob_rd");
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            req_valid = ($urandom % 4) != 0;
            req_op    = 3'($urandom_range(0, 7));
            addr_sel  = 2'($urandom);
            data_sel  = 3'($urandom_range(0, 7));
            rsrc = 16'($urandom); rdst = 16'($urandom);
            alu  = 16'($urandom); sp   = 16'($urandom);
            pc   = $urandom; pc_plus = $urandom;
            flags = 3'($urandom);
            step();
            compare_all("rand");
        end

        // Drain any pending second access before the reset sequence.
        req_valid = 1'b0;
        step();
        compare_all("drain");

        // Reset while the low word of a push is still owed.
        m_rd(11'h0FF, rv);
        drive(1, 3'd3, 2'd3, 16'h0100, 3'd4, 16'h0, 32'hCAFE_F00D);
        step();
        chk("rst_pre_stall", 64'(stall), 64'(1));
        req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        pend = 0; e_stall = 0; e_rdv = 0; e_pcv = 0; e_err = 0; e_rd = '0; e_pc = '0;
        chk("rst_stall",    64'(stall),    64'(0));
        chk("rst_rd_data",  64'(rd_data),  64'(0));
        chk("rst_pc_data",  64'(pc_data),  64'(0));
        chk("rst_addr_err", 64'(addr_err), 64'(0));
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        drive(1, 3'd1, 2'd3, 16'h00FF, 3'd0, 16'h0, 32'h0);
        step();
        chk("rst_lo_unwritten", 64'(rd_data), 64'(rv));
        compare_all("rst_rd_lo");
        drive(1, 3'd1, 2'd3, 16'h0100, 3'd0, 16'h0, 32'h0);
        step();
        chk("rst_hi_written", 64'(rd_data), 64'(16'hCAFE));
        compare_all("rst_rd_hi");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
